rvfpm_commit_sched: RTL and testbench



---
 rtl/rvfpm_commit_sched.sv | 124 ++++++++++++
 tb/tb_rvfpm_commit_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rvfpm_commit_sched.sv
// In-order commit scheduler: holds speculative XIF instructions in a circular
// buffer until committed or killed, then hands committed ones to the FPU in issue order.
module rvfpm_commit_sched #(
  parameter  int DEPTH      = 4,
  parameter  int X_ID_WIDTH = 4,
  parameter  int INSTR_W    = 32,
  localparam int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  input  logic [X_ID_WIDTH-1:0] in_id,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_W-1:0]    out_instr,
  output logic [X_ID_WIDTH-1:0] out_id,
  output logic [CNT_W-1:0]      occupancy,
  output logic [7:0]            kill_cnt,
  output logic                  unmatched_commit
);
  localparam int PW = $clog2(DEPTH);

  logic [INSTR_W-1:0]    instr_q [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
  logic [DEPTH-1:0]      vld_q, vld_d, cmt_q, cmt_d, kil_q, kil_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [7:0]            kill_cnt_q, kill_cnt_d;
  logic                  unm_q, unm_d;

  logic                  enq, hs, drop, pop, match, new_hit;
  logic [PW-1:0]         match_idx, scan_idx;

  assign in_ready  = occ_q < CNT_W'(DEPTH);
  assign enq       = in_valid & in_ready;
  assign drop      = vld_q[head_q] & kil_q[head_q];
  assign out_valid = vld_q[head_q] & cmt_q[head_q] & ~kil_q[head_q];
  assign hs        = out_valid & out_ready;
  assign pop       = drop | hs;

  assign out_instr        = instr_q[head_q];
  assign out_id           = id_q[head_q];
  assign occupancy        = occ_q;
  assign kill_cnt         = kill_cnt_q;
  assign unmatched_commit = unm_q;

  // Scan from head so the first hit is the oldest unresolved entry with this ID.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PW'(k);
      if (!match && vld_q[scan_idx] && !cmt_q[scan_idx] && !kil_q[scan_idx] &&
          id_q[scan_idx] == commit_id) begin
        match     = 1'b1;
        match_idx = scan_idx;
      end
    end
  end

  // A commit only falls through to the incoming entry when nothing older claims it.
  assign new_hit = commit_valid & ~match & enq & (in_id == commit_id);

  always_comb begin
    vld_d      = vld_q;
    cmt_d      = cmt_q;
    kil_d      = kil_q;
    head_d     = head_q;
    tail_d     = tail_q;
    kill_cnt_d = kill_cnt_q;
    unm_d      = commit_valid & ~match & ~new_hit;
    if (commit_valid && match) begin
      if (commit_kill) kil_d[match_idx] = 1'b1;
      else             cmt_d[match_idx] = 1'b1;
    end
    if (enq) begin
      vld_d[tail_q] = 1'b1;
      cmt_d[tail_q] = new_hit & ~commit_kill;
      kil_d[tail_q] = new_hit & commit_kill;
      tail_d        = tail_q + PW'(1);
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (drop && kill_cnt_q != 8'hFF) kill_cnt_d = kill_cnt_q + 8'd1;
    occ_d = occ_q + CNT_W'(enq) - CNT_W'(pop);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      vld_q      <= '0;
      cmt_q      <= '0;
      kil_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      kill_cnt_q <= '0;
      unm_q      <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      cmt_q      <= cmt_d;
      kil_q      <= kil_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      kill_cnt_q <= kill_cnt_d;
      unm_q      <= unm_d;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst && enq) begin
      instr_q[tail_q] <= in_instr;
      id_q[tail_q]    <= in_id;
    end
  end
endmodule

// File: tb/tb_rvfpm_commit_sched.sv
// Directed table-driven bench for rvfpm_commit_sched plus hand-written reset
// and oldest-match sequences.
module tb_rvfpm_commit_sched;
  logic        ck, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [3:0]  in_id;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [3:0]  out_id;
  logic [2:0]  occupancy;
  logic [7:0]  kill_cnt;
  logic        unmatched_commit;

  int n_tot  = 0;
  int n_pass = 0;

  rvfpm_commit_sched #(.DEPTH(4), .X_ID_WIDTH(4), .INSTR_W(32)) dut (
    .ck(ck), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_id(in_id),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_id(out_id),
    .occupancy(occupancy), .kill_cnt(kill_cnt), .unmatched_commit(unmatched_commit)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    int iv; int iid; logic [31:0] instr; int cv; int cid; int kl; int ordy;
    int irdy; int ov; int oid; logic [31:0] oinstr; int occ; int kc; int unm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int iv, int iid, logic [31:0] instr, int cv, int cid, int kl,
                              int ordy, int irdy, int ov, int oid, logic [31:0] oinstr,
                              int occ, int kc, int unm);
    vec_t v;
    v.iv = iv; v.iid = iid; v.instr = instr; v.cv = cv; v.cid = cid; v.kl = kl;
    v.ordy = ordy; v.irdy = irdy; v.ov = ov; v.oid = oid; v.oinstr = oinstr;
    v.occ = occ; v.kc = kc; v.unm = unm;
    return v;
  endfunction

  task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
  endtask

  task automatic drv(int iv, int iid, logic [31:0] instr, int cv, int cid, int kl, int ordy);
    in_valid     = 1'(iv);
    in_id        = 4'(iid);
    in_instr     = instr;
    commit_valid = 1'(cv);
    commit_id    = 4'(cid);
    commit_kill  = 1'(kl);
    out_ready    = 1'(ordy);
  endtask

  task automatic next_cycle();
    @(posedge ck);
    #1;
  endtask

  initial begin
    // basic pass-through
    tbl.push_back(mk(0,0,0,            0,0,0,1, 1,0,0,0,0,0,0));
    tbl.push_back(mk(1,3,32'h00A2F053, 0,0,0,1, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,            1,3,0,1, 1,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,            0,0,0,1, 1,1,3,32'h00A2F053,1,0,0));
    tbl.push_back(mk(0,0,0,            0,0,0,1, 1,0,0,0,0,0,0));
    // fill, back-pressure, rejected 5th, no same-cycle in_ready bypass
    tbl.push_back(mk(1,0,32'h100, 0,0,0,1, 1,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,32'h101, 0,0,0,1, 1,0,0,0,1,0,0));
    tbl.push_back(mk(1,2,32'h102, 0,0,0,1, 1,0,0,0,2,0,0));
    tbl.push_back(mk(1,3,32'h103, 0,0,0,1, 1,0,0,0,3,0,0));
    tbl.push_back(mk(1,4,32'h104, 0,0,0,1, 0,0,0,0,4,0,0));
    tbl.push_back(mk(0,0,0,       1,0,0,1, 0,0,0,0,4,0,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 0,1,0,32'h100,4,0,0));
    tbl.push_back(mk(0,0,0,       1,1,1,1, 1,0,0,0,3,0,0));
    tbl.push_back(mk(0,0,0,       1,2,1,1, 1,0,0,0,3,0,0));
    tbl.push_back(mk(0,0,0,       1,3,1,1, 1,0,0,0,2,1,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,0,0,0,1,2,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,0,0,0,0,3,0));
    // out-of-order resolution, head-of-line blocking
    tbl.push_back(mk(1,1,32'h201, 0,0,0,1, 1,0,0,0,0,3,0));
    tbl.push_back(mk(1,2,32'h202, 0,0,0,1, 1,0,0,0,1,3,0));
    tbl.push_back(mk(1,3,32'h203, 0,0,0,1, 1,0,0,0,2,3,0));
    tbl.push_back(mk(0,0,0,       1,3,0,1, 1,0,0,0,3,3,0));
    tbl.push_back(mk(0,0,0,       1,2,0,1, 1,0,0,0,3,3,0));
    tbl.push_back(mk(0,0,0,       1,1,0,1, 1,0,0,0,3,3,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,1,1,32'h201,3,3,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,1,2,32'h202,2,3,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,1,3,32'h203,1,3,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,0,0,0,0,3,0));
    // kill handling
    tbl.push_back(mk(1,5,32'h305, 0,0,0,1, 1,0,0,0,0,3,0));
    tbl.push_back(mk(1,6,32'h306, 0,0,0,1, 1,0,0,0,1,3,0));
    tbl.push_back(mk(0,0,0,       1,5,1,1, 1,0,0,0,2,3,0));
    tbl.push_back(mk(0,0,0,       1,6,0,1, 1,0,0,0,2,3,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,1,6,32'h306,1,4,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,0,0,0,0,4,0));
    // unmatched on empty, then duplicate commit
    tbl.push_back(mk(0,0,0,       1,9,0,1, 1,0,0,0,0,4,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,0,0,0,0,4,1));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,0,0,0,0,4,0));
    tbl.push_back(mk(1,2,32'h402, 0,0,0,0, 1,0,0,0,0,4,0));
    tbl.push_back(mk(0,0,0,       1,2,0,0, 1,0,0,0,1,4,0));
    tbl.push_back(mk(0,0,0,       1,2,0,0, 1,1,2,32'h402,1,4,0));
    tbl.push_back(mk(0,0,0,       0,0,0,0, 1,1,2,32'h402,1,4,1));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,1,2,32'h402,1,4,0));
    tbl.push_back(mk(0,0,0,       0,0,0,1, 1,0,0,0,0,4,0));
    // same-cycle enqueue+commit, then held under back-pressure
    tbl.push_back(mk(1,7,32'h707, 1,7,0,0, 1,0,0,0,0,4,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,     0,0,0,0, 1,1,7,32'h707,1,4,0));

    rst = 1'b1;
    drv(0,0,0,0,0,0,0);
    repeat (2) @(posedge ck);
    #1;
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      drv(tbl[r].iv, tbl[r].iid, tbl[r].instr, tbl[r].cv, tbl[r].cid, tbl[r].kl, tbl[r].ordy);
      @(negedge ck);
      chk("in_ready",  r, 32'(in_ready),         32'(tbl[r].irdy));
      chk("out_valid", r, 32'(out_valid),        32'(tbl[r].ov));
      chk("occupancy", r, 32'(occupancy),        32'(tbl[r].occ));
      chk("kill_cnt",  r, 32'(kill_cnt),         32'(tbl[r].kc));
      chk("unmatched", r, 32'(unmatched_commit), 32'(tbl[r].unm));
      if (tbl[r].ov != 0) begin
        chk("out_id",    r, 32'(out_id), 32'(tbl[r].oid));
        chk("out_instr", r, out_instr,   tbl[r].oinstr);
      end
      next_cycle();
    end

    // reset while an entry is presented and accepted; inputs in that cycle ignored
    drv(1,4,32'h444,1,7,0,1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drv(0,0,0,0,0,0,1);
    @(negedge ck);
    chk("rst_out_valid", 100, 32'(out_valid),        32'd0);
    chk("rst_occupancy", 100, 32'(occupancy),        32'd0);
    chk("rst_kill_cnt",  100, 32'(kill_cnt),         32'd0);
    chk("rst_unmatched", 100, 32'(unmatched_commit), 32'd0);
    chk("rst_in_ready",  100, 32'(in_ready),         32'd1);
    next_cycle();

    // equal ID enqueued while an older copy is pending: commit goes to the older one
    drv(1,5,32'hA5,0,0,0,0);
    next_cycle();
    drv(1,5,32'hB5,1,5,0,0);
    next_cycle();
    drv(0,0,0,0,0,0,1);
    @(negedge ck);
    chk("old_ov",    101, 32'(out_valid),        32'd1);
    chk("old_id",    101, 32'(out_id),           32'd5);
    chk("old_instr", 101, out_instr,             32'hA5);
    chk("old_occ",   101, 32'(occupancy),        32'd2);
    chk("old_unm",   101, 32'(unmatched_commit), 32'd0);
    next_cycle();
    drv(0,0,0,1,5,0,1);
    @(negedge ck);
    chk("young_wait_ov", 102, 32'(out_valid), 32'd0);
    chk("young_occ",     102, 32'(occupancy), 32'd1);
    next_cycle();
    drv(0,0,0,0,0,0,1);
    @(negedge ck);
    chk("young_ov",    103, 32'(out_valid), 32'd1);
    chk("young_instr", 103, out_instr,      32'hB5);
    next_cycle();
    @(negedge ck);
    chk("final_ov",  104, 32'(out_valid),        32'd0);
    chk("final_occ", 104, 32'(occupancy),        32'd0);
    chk("final_unm", 104, 32'(unmatched_commit), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
